wr_collector: RTL and testbench

- Merges the worker-result streams of NUM_WORKERS parallel worker instances into a single worker-result stream, buffered in a small FIFO.
- Sits directly downstream of the worker array. Its output feeds the token-routing / matching stage.
- Uses the same registered VALID/READY handshake as the workers. A transfer occurs on a rising CLK edge where VALID and READY are both high.

---
 rtl/wr_collector.sv | 149 ++++++++++++++
 tb/tb_wr_collector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_collector.sv
// wr_collector
//   Merges NUM_WORKERS worker-result streams into one stream through a small
//   FIFO. Upstream uses a registered one-hot READY with round-robin grant.
//   At most one grant is in flight, and grants are never back-to-back, so
//   intake is at most one result every two cycles. A grant is only issued
//   when the FIFO has room for it, so the FIFO can never overflow.
//
//   Ports:
//     CLK, RST            clock, synchronous active-high reset
//     RECEIVE_WR_VALID    per-worker result valid (bit i = worker i)
//     RECEIVE_WR_DATA     flattened results, worker i at [i*W +: W]
//     RECEIVE_WR_READY    per-worker ready, registered, one-hot or zero
//     SEND_WR_VALID       head-of-FIFO valid (registered)
//     SEND_WR_DATA        head-of-FIFO result (registered, held when empty)
//     SEND_WR_READY       downstream ready
//   Optional (macro WR_COLLECTOR_STATS_EN):
//     STAT_FORWARDED      wrapping count of output handshakes
//     STAT_STALL          saturating count of cycles with VALID && !READY
module wr_collector #(
  parameter int WORKER_RESULT_WIDTH = 64,
  parameter int NUM_WORKERS         = 4,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                       CLK,
  input  logic                                       RST,
  input  logic [NUM_WORKERS-1:0]                     RECEIVE_WR_VALID,
  input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
  output logic [NUM_WORKERS-1:0]                     RECEIVE_WR_READY,
  output logic                                       SEND_WR_VALID,
  output logic [WORKER_RESULT_WIDTH-1:0]             SEND_WR_DATA,
  input  logic                                       SEND_WR_READY
`ifdef WR_COLLECTOR_STATS_EN
  ,
  output logic [31:0]                                STAT_FORWARDED,
  output logic [31:0]                                STAT_STALL
`endif
);

  localparam int W     = WORKER_RESULT_WIDTH;
  localparam int N     = NUM_WORKERS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(NUM_WORKERS);

  logic [N-1:0][W-1:0] in_data;
  assign in_data = RECEIVE_WR_DATA;

  logic [N-1:0]     ready_q;
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] gnt_idx;

  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             send_valid_q;
  logic [W-1:0]     send_data_q;

  // Round-robin search starting at rr.
  logic             req_found;
  logic [IDX_W-1:0] req_idx;
  int               j;
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr) + k;
      if (j >= N) j = j - N;
      if (!req_found && RECEIVE_WR_VALID[IDX_W'(j)]) begin
        req_found = 1'b1;
        req_idx   = IDX_W'(j);
      end
    end
  end

  // Credit counts the outstanding grant so a grant can never overfill the FIFO.
  logic in_flight, credit, grant;
  assign in_flight = |ready_q;
  assign credit    = (count + CNT_W'(in_flight)) < CNT_W'(FIFO_DEPTH);
  assign grant     = !in_flight && req_found && credit;

  // Accept only if the granted worker still holds VALID in the READY cycle.
  logic         push, pop;
  logic [W-1:0] push_data;
  assign push      = |(ready_q & RECEIVE_WR_VALID);
  assign push_data = in_data[gnt_idx];
  assign pop       = send_valid_q && SEND_WR_READY;

  logic [CNT_W-1:0] count_n;
  logic [PTR_W-1:0] rd_ptr_n, wr_ptr_n;
  logic [W-1:0]     head_n;
  always_comb begin
    count_n  = count + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_n = rd_ptr + PTR_W'(pop);
    wr_ptr_n = wr_ptr + PTR_W'(push);
    // The entry being written this edge becomes the head when it lands at
    // the new read pointer (empty FIFO, or push+pop with one entry).
    head_n   = (push && (wr_ptr == rd_ptr_n)) ? push_data : mem[rd_ptr_n];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ready_q      <= '0;
      gnt_idx      <= '0;
      rr           <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      send_valid_q <= 1'b0;
      send_data_q  <= '0;
    end else begin
      ready_q <= grant ? (N'(1) << req_idx) : '0;
      if (grant) gnt_idx <= req_idx;
      if (push)  rr <= (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + 1'b1;
      rd_ptr       <= rd_ptr_n;
      wr_ptr       <= wr_ptr_n;
      count        <= count_n;
      send_valid_q <= (count_n != '0);
      // When the FIFO goes empty the output data keeps its last value.
      if (count_n != '0) send_data_q <= head_n;
    end
  end

  // Storage needs no reset: it is only observable through count/pointers.
  always_ff @(posedge CLK) begin
    if (!RST && push) mem[wr_ptr] <= push_data;
  end

  assign RECEIVE_WR_READY = ready_q;
  assign SEND_WR_VALID    = send_valid_q;
  assign SEND_WR_DATA     = send_data_q;

`ifdef WR_COLLECTOR_STATS_EN
  logic [31:0] fwd_q, stall_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_q   <= '0;
      stall_q <= '0;
    end else begin
      if (pop) fwd_q <= fwd_q + 32'd1;
      if (send_valid_q && !SEND_WR_READY && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end
  assign STAT_FORWARDED = fwd_q;
  assign STAT_STALL     = stall_q;
`endif

endmodule

// File: tb/tb_wr_collector.sv
// Bench for wr_collector (default parameters: W=64, 4 workers, depth 4).
// Each upstream worker is modelled as a queue of results: VALID is high
// while the queue is non-empty (unless held off), and the head is popped on
// a VALID&READY edge. Expected output results are pushed into a scoreboard
// queue by the stimulus; a negedge monitor pops and compares on every output
// handshake. Cycle-exact timing checks are made inline.
module tb_wr_collector;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   vin;
  logic [255:0] din;
  logic [3:0]   rdy;
  logic         sv;
  logic [63:0]  sd;
  logic         srdy;
`ifdef WR_COLLECTOR_STATS_EN
  logic [31:0]  stat_fwd, stat_stall;
`endif

  wr_collector #(.WORKER_RESULT_WIDTH(64), .NUM_WORKERS(4), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .RECEIVE_WR_VALID(vin), .RECEIVE_WR_DATA(din), .RECEIVE_WR_READY(rdy),
    .SEND_WR_VALID(sv), .SEND_WR_DATA(sd), .SEND_WR_READY(srdy)
`ifdef WR_COLLECTOR_STATS_EN
    , .STAT_FORWARDED(stat_fwd), .STAT_STALL(stat_stall)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];
  logic [63:0] wq [4][$];
  logic [3:0]  hold = '0;
  int accepts = 0, grants = 0, b2b = 0;
  logic [3:0]  prev_rdy = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor / scoreboard.
  always @(negedge CLK) begin
    if (RST === 1'b0 && sv === 1'b1 && srdy === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h expected nothing", sd);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if (sd !== e) begin
          errors++;
          $display("FAIL out_data: got %h expected %h", sd, e);
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      vin[i] = (wq[i].size() != 0) && !hold[i];
      din[i*64 +: 64] = (wq[i].size() != 0) ? wq[i][0] : 64'd0;
    end
  endtask

  task automatic tick();
    logic [3:0] acc;
    acc = RST ? 4'b0 : (vin & rdy);
    if (rdy != 0) grants++;
    if (rdy != 0 && prev_rdy != 0) b2b++;
    prev_rdy = rdy;
    for (int i = 0; i < 4; i++) if (acc[i]) accepts++;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(wq[i].pop_front());
    drive();
  endtask

  task automatic do_reset();
    srdy = 1'b0;
    RST  = 1'b1;
    for (int i = 0; i < 4; i++) wq[i].delete();
    hold = '0;
    drive();
    tick(); tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (rdy == 0 && n < 50) begin tick(); n++; end
    if (rdy == 0) begin
      checks++; errors++;
      $display("FAIL %s: got no grant expected grant within 50 cycles", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((wq[0].size() + wq[1].size() + wq[2].size() + wq[3].size() + sb.size() != 0 || sv)
           && n < 300) begin
      tick(); n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: got pending=%0d expected drained", name, sb.size());
    end
  endtask

  initial begin
    int g0;
    RST = 1'b1; srdy = 1'b0; vin = '0; din = '0;
    tick(); tick();
    chk("rst_ready", 64'(rdy), 64'h0);
    chk("rst_valid", 64'(sv), 64'h0);
    chk("rst_data", sd, 64'h0);
`ifdef WR_COLLECTOR_STATS_EN
    chk("rst_stat_fwd", 64'(stat_fwd), 64'h0);
`endif
    RST = 1'b0;
    tick();

    // Single result, worker 1; latency VALID(t) -> READY(t+1) -> out(t+2).
    srdy = 1'b1;
    wq[1].push_back(64'h0000_0001_0000_002A); sb.push_back(64'h0000_0001_0000_002A);
    drive();
    tick();
    chk("single_ready_t1", 64'(rdy), 64'h2);
    chk("single_valid_t1", 64'(sv), 64'h0);
    tick();
    chk("single_ready_t2", 64'(rdy), 64'h0);
    chk("single_valid_t2", 64'(sv), 64'h1);
    chk("single_data_t2", sd, 64'h0000_0001_0000_002A);
    tick();
    chk("single_valid_t3", 64'(sv), 64'h0);
    chk("single_hold_data", sd, 64'h0000_0001_0000_002A);
    // rr is now 2: workers 0 and 2 both request, 2 wins first.
    wq[0].push_back(64'h600); wq[2].push_back(64'h602);
    sb.push_back(64'h602); sb.push_back(64'h600);
    drive();
    tick();
    chk("rr_after_single", 64'(rdy), 64'h4);
    wait_drain("drain_single");

    // Fairness: all four workers hold VALID, two results each.
    do_reset();
    srdy = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        wq[k].push_back(64'(k + 'h100));
        sb.push_back(64'(k + 'h100));
      end
    drive();
    g0 = grants;
    for (int c = 0; c < 18; c++) tick();
    chk("fair_grants", 64'(grants - g0), 64'd8);
    wait_drain("drain_fair");

    // Backpressure: FIFO fills with exactly 4 entries, then no grants.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wq[0].push_back(64'(k + 'h200));
      wq[1].push_back(64'(k + 'h210));
    end
    sb.push_back(64'h200); sb.push_back(64'h210); sb.push_back(64'h201);
    sb.push_back(64'h211); sb.push_back(64'h202); sb.push_back(64'h212);
    drive();
    accepts = 0;
    for (int c = 0; c < 12; c++) tick();
    g0 = grants;
    for (int c = 0; c < 10; c++) tick();
    chk("full_accepts", 64'(accepts), 64'd4);
    chk("full_no_grant", 64'(grants - g0), 64'd0);
    chk("full_valid", 64'(sv), 64'h1);
    chk("full_head", sd, 64'h200);
`ifdef WR_COLLECTOR_STATS_EN
    chk("stall_nonzero", 64'(stat_stall != 0), 64'h1);
`endif
    srdy = 1'b1;
    wait_drain("drain_full");

    // Simultaneous push and pop with one entry.
    do_reset();
    wq[3].push_back(64'h300); sb.push_back(64'h300); sb.push_back(64'h301);
    drive();
    tick(); tick(); tick();
    chk("pp_first_valid", 64'(sv), 64'h1);
    wq[1].push_back(64'h301);
    drive();
    wait_grant("pp_grant");
    chk("pp_grant_w1", 64'(rdy), 64'h2);
    srdy = 1'b1;
    tick();
    chk("pp_valid_kept", 64'(sv), 64'h1);
    chk("pp_data_new", sd, 64'h301);
    tick();
    chk("pp_empty", 64'(sv), 64'h0);
    wait_drain("drain_pp");

    // Withdrawn VALID in the READY cycle.
    do_reset();
    srdy = 1'b1;
    wq[2].push_back(64'h400);
    drive();
    wait_grant("wd_grant");
    chk("wd_grant_w2", 64'(rdy), 64'h4);
    hold[2] = 1'b1;
    wq[1].push_back(64'h410); wq[3].push_back(64'h430);
    sb.push_back(64'h410); sb.push_back(64'h430);
    drive();
    tick();
    chk("wd_no_write", 64'(sv), 64'h0);
    chk("wd_ready_low", 64'(rdy), 64'h0);
    tick();
    chk("wd_next_w1", 64'(rdy), 64'h2);
    wq[2].delete(); hold[2] = 1'b0;
    drive();
    wait_drain("drain_wd");

    // Reset mid-operation: 3 entries queued, 4th grant outstanding.
    do_reset();
    wq[0].push_back(64'h500); wq[0].push_back(64'h501); wq[0].push_back(64'h502);
    wq[1].push_back(64'h510);
    drive();
    accepts = 0;
    for (int c = 0; c < 50 && !(accepts == 3 && rdy != 0); c++) tick();
    chk("rm_grant_w0", 64'(rdy), 64'h1);
    chk("rm_accepts", 64'(accepts), 64'd3);
    RST = 1'b1;
    tick();
    chk("rm_valid", 64'(sv), 64'h0);
    chk("rm_ready", 64'(rdy), 64'h0);
`ifdef WR_COLLECTOR_STATS_EN
    chk("rm_stat_fwd", 64'(stat_fwd), 64'h0);
`endif
    RST = 1'b0;
    for (int i = 0; i < 4; i++) wq[i].delete();
    srdy = 1'b1;
    wq[0].push_back(64'h5AA); sb.push_back(64'h5AA);
    drive();
    tick();
    chk("rm_regrant", 64'(rdy), 64'h1);
    tick();
    chk("rm_out_valid", 64'(sv), 64'h1);
    chk("rm_out_data", sd, 64'h5AA);
    wait_drain("drain_rm");

    // Four more results (rr=1 after worker 0): order 1,2,3,0.
    for (int k = 0; k < 4; k++) wq[k].push_back(64'(k + 'h700));
    sb.push_back(64'h701); sb.push_back(64'h702); sb.push_back(64'h703); sb.push_back(64'h700);
    drive();
    wait_drain("drain_final");
`ifdef WR_COLLECTOR_STATS_EN
    chk("stat_fwd_5", 64'(stat_fwd), 64'd5);
`endif
    chk("no_b2b_grants", 64'(b2b), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
